// File: rtl/sdp_ram_pkg.sv
// Shared definitions for the SDP RAM AXI4 read front-end.
//   - AXI burst-type encodings and the OKAY response code
//   - Read-controller FSM state type
package sdp_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RRESP_OKAY  = 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

endpackage

// File: rtl/sdp_rdata_fifo.sv
// Synchronous FIFO buffering R-channel beats (data plus last flag).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (empties the FIFO)
//   push_i, din_i      write strobe and entry
//   pop_i, dout_o      read strobe and head entry (valid while !empty_o)
//   count_o, empty_o   occupancy and empty flag
// Depth must be a power of two so the pointers wrap naturally.
module sdp_rdata_fifo #(
  parameter int unsigned Width = 513,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           din_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           dout_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; entries are only observed once written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/sdp_ram_rd_if.sv
// AXI4 read-channel slave returning bursts from the read port of a simple-dual-port RAM.
// One burst outstanding at a time; beats are buffered in a small FIFO to absorb RREADY stalls.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   ram_addr, ram_dout RAM read port (data valid one clock after the address is sampled)
//   S_AXI_AR*          read-address channel (ARSIZE ignored, full-width beats only)
//   S_AXI_R*           read-data channel (RRESP always OKAY)
// Optional build macro SDP_RD_FIXED_BURST_EN: when defined, FIXED bursts reread the same word;
// otherwise FIXED (like WRAP and reserved) is treated as INCR.
module sdp_ram_rd_if
  import sdp_ram_pkg::*;
#(
  parameter int unsigned DW         = 512,
  parameter int unsigned DD         = 16384,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  output logic [$clog2(DD)-1:0]           ram_addr,
  input  logic [DW-1:0]                   ram_dout,
  input  logic [$clog2(DD*(DW/8))-1:0]    S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  input  logic [3:0]                      S_AXI_ARID,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic [2:0]                      S_AXI_ARSIZE,
  output logic                            S_AXI_ARREADY,
  output logic [DW-1:0]                   S_AXI_RDATA,
  output logic [3:0]                      S_AXI_RID,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int unsigned AW   = $clog2(DD);
  localparam int unsigned OFFW = $clog2(DW / 8);
  localparam int unsigned AXW  = $clog2(DD * (DW / 8));
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [8:0]    beats_q, beats_d;
  logic [3:0]    id_q, id_d;
  logic          fixed_q, fixed_d;
  logic          arready_q, arready_d;
  logic          in_flight_q, in_last_q;

  logic          issue, ar_hs, r_hs, credit;
  logic          fifo_empty;
  logic [DW:0]   fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic [AW-1:0] addr_next;
  logic          unused_inputs;

  assign unused_inputs = ^{S_AXI_ARSIZE, S_AXI_ARADDR[OFFW-1:0], S_AXI_ARBURST};

  assign ar_hs = S_AXI_ARVALID & arready_q;
  assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;

  // Registered terms only: RREADY cannot reach ram_addr combinationally. Keeping
  // occupancy <= DEPTH-2 at issue leaves room for the read still in the RAM pipe.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(in_flight_q);
  assign credit    = (occupancy <= (CW+1)'(FIFO_DEPTH - 2));

  always_comb begin
    addr_next = addr_q;
    if (!fixed_q) begin
      addr_next = (addr_q == AW'(DD - 1)) ? '0 : addr_q + AW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    id_d    = id_q;
    fixed_d = fixed_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          addr_d  = S_AXI_ARADDR[AXW-1:OFFW];
          beats_d = 9'(S_AXI_ARLEN) + 9'd1;
          id_d    = S_AXI_ARID;
`ifdef SDP_RD_FIXED_BURST_EN
          fixed_d = (S_AXI_ARBURST == BURST_FIXED);
`else
          fixed_d = 1'b0;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The RAM samples ram_addr on this edge; advance to the next word.
        if (credit) begin
          issue   = 1'b1;
          beats_d = beats_q - 9'd1;
          addr_d  = addr_next;
          if (beats_q == 9'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (r_hs && S_AXI_RLAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    arready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      beats_q     <= '0;
      id_q        <= '0;
      fixed_q     <= 1'b0;
      arready_q   <= 1'b0;
      in_flight_q <= 1'b0;
      in_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      id_q        <= id_d;
      fixed_q     <= fixed_d;
      arready_q   <= arready_d;
      in_flight_q <= issue;
      in_last_q   <= issue & (beats_q == 9'd1);
    end
  end

  sdp_rdata_fifo #(
    .Width (DW + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (in_flight_q),
    .din_i   ({in_last_q, ram_dout}),
    .pop_i   (r_hs),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign ram_addr      = addr_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = ~fifo_empty;
  assign S_AXI_RDATA   = fifo_dout[DW-1:0];
  assign S_AXI_RLAST   = ~fifo_empty & fifo_dout[DW];
  assign S_AXI_RID     = id_q;
  assign S_AXI_RRESP   = RRESP_OKAY;

endmodule
